// File: rtl/clkgen_pkg.sv
// clkgen_pkg
// Shared definitions for the fractional clock-enable generator:
//   - ACC_W_DEFAULT : default accumulator / increment width
//   - lock_state_e  : encoding of the lock FSM (SETTLING / LOCKED)
//   - chan_idx_w()  : width of a channel index, never less than one bit
package clkgen_pkg;

  localparam int ACC_W_DEFAULT = 24;

  typedef enum logic [0:0] {
    LOCK_SETTLING = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  // A single-channel build still needs a one-bit index port.
  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/frac_clken_gen_phase_acc.sv
// phase_acc
// One channel of the fractional clock-enable generator: an increment
// register, a phase accumulator and a registered carry strobe.
// Ports:
//   clock_in    system clock
//   reset       synchronous active-high reset (acc/clken cleared, inc = DEFAULT_INC)
//   wr_en       load wr_inc into the increment register (already decoded for this channel)
//   wr_inc      new increment value
//   sync        clear accumulator and strobe (phase alignment)
//   clken       one-cycle enable strobe, high the cycle after the accumulator overflows
module phase_acc
  import clkgen_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEFAULT,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             sync,
  output logic             clken
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // The extra top bit of the sum is the overflow that becomes the strobe.
  assign sum = {1'b0, acc} + {1'b0, inc};

  // The sum uses the increment held before this edge, so a new value
  // written now only affects the accumulation at the next edge. A write
  // leaves the accumulator phase untouched.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      acc   <= '0;
      inc   <= DEFAULT_INC;
      clken <= 1'b0;
    end else begin
      if (wr_en) begin
        inc <= wr_inc;
      end
      if (sync) begin
        acc   <= '0;
        clken <= 1'b0;
      end else begin
        acc   <= sum[ACC_W-1:0];
        clken <= sum[ACC_W];
      end
    end
  end

endmodule

// File: rtl/frac_clken_gen.sv
// frac_clken_gen
// CHANNELS independent phase accumulators on one system clock, each giving
// a one-cycle enable strobe at an average rate of inc / 2^ACC_W of the clock.
// A lock flag reports that all rates have been stable for SETTLE cycles.
// Ports:
//   clock_in    system clock
//   reset       synchronous active-high reset
//   wr_en       write strobe for one increment register
//   wr_chan     channel index of the write; indices >= CHANNELS are ignored
//   wr_inc      new increment value
//   sync        clear all accumulators so channels restart phase-aligned
//   clken       per-channel registered enable strobes (channel 0 in bit 0)
//   locked      high while rates are settled
module frac_clken_gen
  import clkgen_pkg::*;
#(
  parameter int                        CHANNELS    = 2,
  parameter int                        ACC_W       = ACC_W_DEFAULT,
  parameter int                        SETTLE      = 16,
  parameter logic [CHANNELS*ACC_W-1:0] DEFAULT_INC = {CHANNELS{24'h100000}}
) (
  input  logic                              clock_in,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [chan_idx_w(CHANNELS)-1:0]   wr_chan,
  input  logic [ACC_W-1:0]                  wr_inc,
  input  logic                              sync,
  output logic [CHANNELS-1:0]               clken,
  output logic                              locked
);

  localparam logic [0:0] ST_SETTLING = LOCK_SETTLING;
  localparam logic [0:0] ST_LOCKED   = LOCK_LOCKED;

  // Counter only has to hold SETTLE-1.
  localparam int              CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  logic                valid_wr;
  logic [CHANNELS-1:0] chan_wr;
  logic                restart;
  logic [0:0]          state;
  logic [CNT_W-1:0]    count;
  logic                post_reset;

  // A write to a non-existent channel is dropped entirely, including its
  // effect on the lock flag.
  assign valid_wr = wr_en && (int'(wr_chan) < CHANNELS);
  assign restart  = valid_wr || sync;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan_wr[i] = valid_wr && (int'(wr_chan) == i);

    phase_acc #(
      .ACC_W       (ACC_W),
      .DEFAULT_INC (DEFAULT_INC[i*ACC_W +: ACC_W])
    ) u_acc (
      .clock_in (clock_in),
      .reset    (reset),
      .wr_en    (chan_wr[i]),
      .wr_inc   (wr_inc),
      .sync     (sync),
      .clken    (clken[i])
    );
  end

  // Lock FSM. Any valid write or sync reloads the counter, so simultaneous
  // write and sync restart it only once. The first edge after reset release
  // behaves like a restarting edge, so the lock rises SETTLE cycles after
  // that edge, matching the timing seen after a write or sync.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= ST_SETTLING;
      count      <= CNT_RELOAD;
      post_reset <= 1'b1;
    end else begin
      post_reset <= 1'b0;
      if (restart || post_reset) begin
        state <= ST_SETTLING;
        count <= CNT_RELOAD;
      end else if (state == ST_SETTLING) begin
        if (count == '0) begin
          state <= ST_LOCKED;
        end else begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb_frac_clken_gen
// Self-checking bench for frac_clken_gen with three channels, so that a
// two-bit channel index can address a channel that does not exist (index 3).
// The reference model tracks each channel's total phase as an unbounded
// integer; a strobe occurs whenever the whole-cycle count phase / 2^24
// steps up. Lock is modelled as "edges since the last restart >= SETTLE".
module tb_frac_clken_gen;

  localparam int CH     = 3;
  localparam int AW     = 24;
  localparam int SETTLE = 16;
  localparam logic [CH*AW-1:0] DEF_INC = {CH{24'h100000}};
  localparam longint FULL = 64'd1 << AW;

  logic          clock_in = 1'b0;
  logic          reset    = 1'b1;
  logic          wr_en    = 1'b0;
  logic [1:0]    wr_chan  = 2'd0;
  logic [AW-1:0] wr_inc   = '0;
  logic          sync     = 1'b0;
  logic [CH-1:0] clken;
  logic          locked;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // reference model state
  longint        phase [CH];
  longint        m_inc [CH];
  logic [CH-1:0] m_clken;
  int            since;

  typedef struct {
    logic          rst;
    logic          we;
    logic [1:0]    ch;
    logic [AW-1:0] inc;
    logic          s;
    logic [CH-1:0] exp_clken;
    logic          exp_locked;
  } vec_t;

  vec_t vecs [36];

  int cnt0, cnt1, cnt2, last_hit, bad_gaps;
  logic          r_rst, r_we, r_s;
  logic [1:0]    r_ch;
  logic [AW-1:0] r_inc;

  frac_clken_gen #(
    .CHANNELS    (CH),
    .ACC_W       (AW),
    .SETTLE      (SETTLE),
    .DEFAULT_INC (DEF_INC)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_chan  (wr_chan),
    .wr_inc   (wr_inc),
    .sync     (sync),
    .clken    (clken),
    .locked   (locked)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_val(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cycle);
    end
  endtask

  // Advance the model by one clock edge with the inputs applied at that edge.
  function automatic void model_step(input logic r, input logic we, input logic [1:0] ch,
                                     input logic [AW-1:0] inc, input logic s);
    logic valid;
    valid = we && (int'(ch) < CH);
    if (r) begin
      for (int i = 0; i < CH; i++) begin
        phase[i] = 0;
        m_inc[i] = longint'(DEF_INC[i*AW +: AW]);
      end
      m_clken = '0;
      since   = -1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (s) begin
          phase[i]   = 0;
          m_clken[i] = 1'b0;
        end else begin
          m_clken[i] = ((phase[i] + m_inc[i]) / FULL) != (phase[i] / FULL);
          phase[i]   = phase[i] + m_inc[i];
        end
      end
      if (valid) m_inc[ch] = longint'(inc);
      if (valid || s) since = 0;
      else if (since < SETTLE) since++;
    end
  endfunction

  task automatic check_output();
    check_val("model_clken", longint'(clken), longint'(m_clken));
    check_val("model_locked", longint'(locked), longint'(since >= SETTLE));
  endtask

  task automatic apply_stimulus(input logic r, input logic we, input logic [1:0] ch,
                                input logic [AW-1:0] inc, input logic s);
    reset   = r;
    wr_en   = we;
    wr_chan = ch;
    wr_inc  = inc;
    sync    = s;
    @(posedge clock_in);
    model_step(r, we, ch, inc, s);
    cycle++;
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    // Table: row 0 is the first edge after reset release. Default rate is
    // one strobe per 16 cycles on every channel; channel 1 is rewritten to
    // 1/2 at row 18 while locked.
    for (int j = 0; j < 36; j++) begin
      vecs[j].rst          = 1'b0;
      vecs[j].we           = (j == 18);
      vecs[j].ch           = 2'd1;
      vecs[j].inc          = 24'h800000;
      vecs[j].s            = 1'b0;
      vecs[j].exp_clken[0] = (j % 16 == 15);
      vecs[j].exp_clken[2] = (j % 16 == 15);
      vecs[j].exp_clken[1] = (j <= 18) ? (j % 16 == 15) : (j >= 20 && j % 2 == 0);
      vecs[j].exp_locked   = (j >= 16 && j < 18) || (j >= 34);
    end

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 2'd0, '0, 1'b0);
    check_val("reset_clken", longint'(clken), 0);
    check_val("reset_locked", longint'(locked), 0);

    for (int j = 0; j < 36; j++) begin
      apply_stimulus(vecs[j].rst, vecs[j].we, vecs[j].ch, vecs[j].inc, vecs[j].s);
      check_val("table_clken", longint'(clken), longint'(vecs[j].exp_clken));
      check_val("table_locked", longint'(locked), longint'(vecs[j].exp_locked));
    end

    // inc = 0 on channel 0: no strobes at all
    apply_stimulus(1'b0, 1'b1, 2'd0, 24'h000000, 1'b0);
    cnt0 = 0;
    for (int i = 0; i < 1000; i++) begin
      idle(1);
      if (clken[0]) cnt0++;
    end
    check_val("inc_zero_count", cnt0, 0);

    // maximum increment: strobes on all but at most one cycle
    apply_stimulus(1'b0, 1'b1, 2'd0, 24'hFFFFFF, 1'b0);
    cnt0 = 0;
    for (int i = 0; i < 1000; i++) begin
      idle(1);
      if (clken[0]) cnt0++;
    end
    check_range("inc_max_count", cnt0, 999, 1000);

    // one-third rate: count and gap distribution
    apply_stimulus(1'b0, 1'b1, 2'd0, 24'h555555, 1'b0);
    cnt0 = 0; last_hit = -1; bad_gaps = 0;
    for (int i = 0; i < 30000; i++) begin
      idle(1);
      if (clken[0]) begin
        cnt0++;
        if (last_hit >= 0 && (i - last_hit < 2 || i - last_hit > 4)) bad_gaps++;
        last_hit = i;
      end
    end
    check_range("third_count", cnt0, 9999, 10001);
    check_val("third_bad_gaps", bad_gaps, 0);

    // sync together with a write: both apply, lock restarts once
    idle(2);
    check_val("pre_sync_locked", longint'(locked), 1);
    apply_stimulus(1'b0, 1'b1, 2'd0, 24'h100000, 1'b1);
    check_val("sync_clken", longint'(clken), 0);
    check_val("sync_locked_fall", longint'(locked), 0);
    idle(14);
    idle(1);
    check_val("sync_locked_early", longint'(locked), 0);
    idle(1);
    check_val("sync_locked_rise", longint'(locked), 1);

    // write to channel index 3 does not exist: nothing changes
    apply_stimulus(1'b0, 1'b1, 2'd3, 24'h000000, 1'b0);
    check_val("invalid_wr_locked", longint'(locked), 1);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (clken[0]) cnt0++;
      if (clken[1]) cnt1++;
      if (clken[2]) cnt2++;
    end
    check_val("invalid_wr_ch0", cnt0, 1);
    check_val("invalid_wr_ch1", cnt1, 8);
    check_val("invalid_wr_ch2", cnt2, 1);

    // reset mid-settling, asserted together with write and sync
    apply_stimulus(1'b0, 1'b1, 2'd0, 24'h400000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd2, 24'h020000, 1'b0);
    idle(3);
    apply_stimulus(1'b1, 1'b1, 2'd1, 24'hFFFFFF, 1'b1);
    check_val("midreset_clken", longint'(clken), 0);
    check_val("midreset_locked", longint'(locked), 0);
    for (int j = 0; j < 16; j++) begin
      idle(1);
      check_val("midreset_default_rate", longint'(clken), (j == 15) ? 7 : 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = ($urandom_range(0, 15) == 0);
      r_ch  = 2'($urandom_range(0, 3));
      r_inc = 24'($urandom) >> $urandom_range(0, 10);
      r_s   = ($urandom_range(0, 63) == 0);
      apply_stimulus(r_rst, r_we, r_ch, r_inc, r_s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
